// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC encoder frame sequencer.
package ldpc_pkg;

  localparam int K_INFO     = 4320;       // information bits per frame
  localparam int Z          = 360;        // circulant size = parity bit count
  localparam int NUM_GROUPS = 12;         // K_INFO / Z
  localparam int CLR_CYC    = 3;          // accumulator clear cycles per frame
  localparam int N_CW       = K_INFO + Z; // serial codeword length
  localparam int CNT_W      = 13;
  localparam int ADDR_W     = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_PARITY,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/ldpc_out_mux.sv
// Output register stage: merges the systematic stream with the delayed parity
// read-back and generates the frame markers.
module ldpc_out_mux
  import ldpc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sys_vld,    // upstream transfer this cycle
  input  logic sys_data,
  input  logic sys_first,  // transfer carries info bit 0
  input  logic par_vld,    // parity read issued this cycle
  input  logic par_last,   // read is for address 0
  input  logic par_data,   // encoder data, one cycle after the read
  output logic m_valid,
  output logic m_data,
  output logic m_sop,
  output logic m_eop,
  output logic frame_done
);

  // Parity data returns one cycle after the read, so its qualifiers are delayed
  // to line up with par_data.
  logic par_vld_d, par_last_d;

  // Delay line for parity qualifiers and the registered output beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_vld_d  <= 1'b0;
      par_last_d <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= 1'b0;
      m_sop      <= 1'b0;
      m_eop      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      par_vld_d  <= par_vld;
      par_last_d <= par_vld & par_last;
      // Systematic and parity phases are separated by SETTLE, never both.
      m_valid    <= sys_vld | par_vld_d;
      m_data     <= sys_vld ? sys_data : (par_vld_d & par_data);
      m_sop      <= sys_vld & sys_first;
      m_eop      <= par_last_d;
      frame_done <= par_last_d;
    end
  end

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer for the quasi-cyclic LDPC parity accumulator: clears it,
// feeds K_INFO bits with a running index, then reads Z parity bits out
// MSB index first and emits the serial codeword.
module ldpc_enc_ctrl
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic              s_data,
  output logic              s_ready,
  output logic              enc_rst_n,
  output logic              enc_din_valid,
  output logic              enc_din,
  output logic [CNT_W-1:0]  enc_counter,
  output logic [ADDR_W-1:0] enc_out_addr,
  output logic              enc_check,
  input  logic              enc_dout,
  output logic              m_valid,
  output logic              m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0]  CLR_LAST   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(K_INFO - 1);
  localparam logic [CNT_W-1:0]  PAR_LAST   = CNT_W'(Z - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TOP   = ADDR_W'(Z - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;    // shared by CLEAR, LOAD, PARITY, DRAIN
  logic [ADDR_W-1:0] addr, addr_nx;
  logic              xfer;

  assign s_ready       = (state == S_LOAD);
  assign xfer          = s_valid & s_ready;
  assign enc_din_valid = xfer;
  assign enc_din       = s_data;
  // The shared counter also times CLEAR/PARITY; the encoder only sees it in LOAD.
  assign enc_counter   = (state == S_LOAD) ? cnt : '0;
  assign enc_out_addr  = addr;
  assign enc_check     = (state == S_PARITY);
  assign enc_rst_n     = rst_n & (state != S_CLEAR);
  assign busy          = (state != S_IDLE);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr  <= ADDR_TOP;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        if (cnt == CLR_LAST) begin
          state_nx = S_LOAD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (cnt == LOAD_LAST) begin
            state_nx = S_SETTLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      S_SETTLE: begin
        state_nx = S_PARITY;
        cnt_nx   = '0;
        addr_nx  = ADDR_TOP;
      end
      S_PARITY: begin
        if (cnt == PAR_LAST) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
          addr_nx  = ADDR_TOP;
        end else begin
          cnt_nx  = cnt + CNT_W'(1);
          addr_nx = addr - ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        addr_nx  = ADDR_TOP;
      end
    endcase
  end

  ldpc_out_mux u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_vld    (xfer),
    .sys_data   (s_data),
    .sys_first  (enc_counter == '0),
    .par_vld    (enc_check),
    .par_last   (addr == '0),
    .par_data   (enc_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .frame_done (frame_done)
  );

endmodule
